// File: rtl/dma_periph_req.sv
// Purpose: byte FIFO feeding an 8237-style DMA channel through a DREQ/DACK/IOR_N handshake.
// Latency: DREQ rises one cycle after LEVEL reaches THRESH. DB/DB_OE follow DACK and IOR_N combinationally.
// Backpressure: a PUSH while FULL is dropped unless a pop happens in the same cycle.
module dma_periph_req #(
    parameter int DEPTH  = 4,
    parameter int THRESH = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   DREQ_POL,
    input  logic                   DACK_POL,
    input  logic                   DEMAND,
    input  logic                   PUSH,
    input  logic [7:0]             DIN,
    input  logic                   FLUSH,
    input  logic                   DACK,
    input  logic                   IOR_N,
    input  logic                   EOP_N,
    output logic                   DREQ,
    output logic [7:0]             DB,
    output logic                   DB_OE,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   DONE
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_XFER,
        S_HOLDOFF
    } state_t;

    state_t          state;
    logic            req_int;
    logic            flush_pend;
    logic            done_q;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            dack_act;
    logic            in_xfer_phase;
    logic            eop_hit;
    logic            strobe_done;
    logic            pop;
    logic            push_ok;

    // Handshake decode: normalise DACK, detect EOP and the completed read strobe.
    always_comb begin
        dack_act      = DACK ^ DACK_POL;
        in_xfer_phase = (state == S_ACK) || (state == S_XFER);
        eop_hit       = in_xfer_phase && !EOP_N;
        // In XFER, IOR_N is known to have been low, so high now is its rising edge.
        strobe_done   = (state == S_XFER) && IOR_N;
        pop           = strobe_done && (count != '0);
        // A full FIFO still takes a write when the head is leaving this cycle.
        push_ok       = PUSH && ((count != DEPTH_C) || pop);
        count_nxt     = count + CW'(push_ok) - CW'(pop);
    end

    // Request/acknowledge sequencer; req_int is the registered request level.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            req_int <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((count >= THRESH_C) || (flush_pend && (count != '0))) begin
                        state   <= S_REQ;
                        req_int <= 1'b1;
                    end
                end
                S_REQ: begin
                    req_int <= 1'b1;
                    if (dack_act) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (eop_hit) begin
                        state   <= S_HOLDOFF;
                        req_int <= 1'b0;
                    end else if (!dack_act) begin
                        // Controller withdrew before any strobe: keep data, start over.
                        state   <= S_IDLE;
                        req_int <= 1'b0;
                    end else if (!IOR_N) begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (eop_hit) begin
                        state   <= S_HOLDOFF;
                        req_int <= 1'b0;
                    end else if (strobe_done) begin
                        if (DEMAND && (count_nxt != '0)) begin
                            state <= S_ACK;
                        end else begin
                            state   <= S_HOLDOFF;
                            req_int <= 1'b0;
                        end
                    end else if (!dack_act) begin
                        state   <= S_IDLE;
                        req_int <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    req_int <= 1'b0;
                    if (!dack_act) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    req_int <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy, flush request and sticky done flag.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            flush_pend <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;

            if (eop_hit) begin
                flush_pend <= 1'b0;
            end else if (FLUSH) begin
                flush_pend <= 1'b1;
            end else if (count_nxt == '0) begin
                flush_pend <= 1'b0;
            end

            if (eop_hit) begin
                done_q <= 1'b1;
            end else if (PUSH && (state == S_IDLE)) begin
                done_q <= 1'b0;
            end
        end
    end

    // Storage array; written on accepted pushes only, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= DIN;
        end
    end

    // Output drive: polarity applied to the request, bus enabled only during a read strobe.
    always_comb begin
        DREQ  = req_int ^ DREQ_POL;
        DB_OE = in_xfer_phase && dack_act && !IOR_N;
        DB    = DB_OE ? mem[rd_ptr] : 8'h00;
        FULL  = (count == DEPTH_C);
        LEVEL = count;
        DONE  = done_q;
    end

endmodule
